pong_match_controller: RTL and testbench

- Game-flow sequencer between the debounced start button and the ball/paddle physics engine. It replaces the bare run toggle.
- Owns the match state: idle, serve, play, pause, point and game over. Also owns the BCD scores for both players and the serve direction.
- Consumes score-event pulses from the physics engine. Feeds the run enable and ball re-centre to the engine, and BCD digits to the seven-segment controller.

---
 rtl/pong_match_controller_if.sv | 26 ++
 rtl/pong_match_controller.sv | 116 +++++++++++
 tb/tb_pong_match_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_controller_if.sv
// pong_match_controller_if: game-flow signals between controller, physics engine and score display
// master: drives tick/start/score pulses and reads run/ball_reset/serve_dir/game_over/winner/BCD digits
// slave: the match controller, consuming the inputs and driving the registered outputs
interface pong_match_controller_if;
  logic       tick;
  logic       start;
  logic       score_p1;
  logic       score_p2;
  logic       run;
  logic       ball_reset;
  logic       serve_dir;
  logic       game_over;
  logic       winner;
  logic [3:0] p1_ones;
  logic [3:0] p1_tens;
  logic [3:0] p2_ones;
  logic [3:0] p2_tens;
  modport master (
    output tick, start, score_p1, score_p2,
    input  run, ball_reset, serve_dir, game_over, winner, p1_ones, p1_tens, p2_ones, p2_tens
  );
  modport slave (
    input  tick, start, score_p1, score_p2,
    output run, ball_reset, serve_dir, game_over, winner, p1_ones, p1_tens, p2_ones, p2_tens
  );
endinterface

// File: rtl/pong_match_controller.sv
// pong_match_controller: pong match sequencer owning state, BCD scores and serve direction
// clk/clr: clock and synchronous active-high reset
// m (slave): tick/start/score_p1/score_p2 in; run/ball_reset/serve_dir/game_over/winner/BCD digits out
module pong_match_controller #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 30
) (
  input logic clk,
  input logic clr,
  pong_match_controller_if.slave m
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] POINT = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;
  localparam int MAXT = SERVE_TICKS > POINT_TICKS ? SERVE_TICKS : POINT_TICKS;
  localparam int CW = MAXT > 0 ? $clog2(MAXT + 1) : 1;
  localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_TICKS);
  localparam logic [CW-1:0] POINT_LD = CW'(POINT_TICKS);
  localparam logic [6:0] WIN = 7'(WIN_SCORE);
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
  logic [7:0]    p1_q, p1_d, p2_q, p2_d;
  logic          start_q, press, expire, p1_win, p2_win;
  logic          run_q, ball_reset_q, serve_dir_q, serve_dir_d, game_over_q, winner_q, winner_d;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v == 8'h99 ? v : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [6:0] bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction
  assign press   = m.start & ~start_q;
  // a zero load expires immediately so a zero-length delay still lasts one clk
  assign expire  = cnt_q == '0 || (m.tick && cnt_q == CW'(1));
  assign cnt_dec = m.tick && cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
  assign p1_win  = bin(p1_q) == WIN;
  assign p2_win  = bin(p2_q) == WIN;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      IDLE: if (press) begin
        state_d = SERVE;
        cnt_d   = SERVE_LD;
      end
      SERVE: begin
        cnt_d   = cnt_dec;
        state_d = expire ? PLAY : SERVE;
      end
      PLAY: if (m.score_p1 || m.score_p2) begin
        p1_d        = m.score_p1 ? bcd_inc(p1_q) : p1_q;
        p2_d        = m.score_p1 ? p2_q : bcd_inc(p2_q);
        serve_dir_d = m.score_p1;
        state_d     = POINT;
        cnt_d       = POINT_LD;
      end else if (press) state_d = PAUSE;
      PAUSE: state_d = press ? PLAY : PAUSE;
      POINT: begin
        cnt_d = cnt_dec;
        if (expire) begin
          state_d  = p1_win || p2_win ? OVER : SERVE;
          cnt_d    = p1_win || p2_win ? cnt_dec : SERVE_LD;
          winner_d = p1_win || p2_win ? ~p1_win : winner_q;
        end
      end
      OVER: if (press) begin
        state_d     = IDLE;
        p1_d        = '0;
        p2_d        = '0;
        serve_dir_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b1;
      p1_q         <= '0;
      p2_q         <= '0;
      run_q        <= 1'b0;
      ball_reset_q <= 1'b1;
      serve_dir_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= m.start;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      run_q        <= state_d == PLAY;
      ball_reset_q <= state_d != PLAY && state_d != PAUSE;
      serve_dir_q  <= serve_dir_d;
      game_over_q  <= state_d == OVER;
      winner_q     <= winner_d;
    end
  end
  assign m.run        = run_q;
  assign m.ball_reset = ball_reset_q;
  assign m.serve_dir  = serve_dir_q;
  assign m.game_over  = game_over_q;
  assign m.winner     = winner_q;
  assign m.p1_tens    = p1_q[7:4];
  assign m.p1_ones    = p1_q[3:0];
  assign m.p2_tens    = p2_q[7:4];
  assign m.p2_ones    = p2_q[3:0];
endmodule

// File: tb/tb_pong_match_controller.sv
// tb_pong_match_controller: scoreboard bench for two controller configurations
module tb_pong_match_controller;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  logic tick[2], start[2], sp1[2], sp2[2];
  wire [20:0] outv[2];
  pong_match_controller_if ifa();
  pong_match_controller_if ifb();
  assign ifa.tick = tick[0];
  assign ifa.start = start[0];
  assign ifa.score_p1 = sp1[0];
  assign ifa.score_p2 = sp2[0];
  assign ifb.tick = tick[1];
  assign ifb.start = start[1];
  assign ifb.score_p1 = sp1[1];
  assign ifb.score_p2 = sp2[1];
  assign outv[0] = {ifa.run, ifa.ball_reset, ifa.serve_dir, ifa.game_over, ifa.winner,
                    ifa.p1_tens, ifa.p1_ones, ifa.p2_tens, ifa.p2_ones};
  assign outv[1] = {ifb.run, ifb.ball_reset, ifb.serve_dir, ifb.game_over, ifb.winner,
                    ifb.p1_tens, ifb.p1_ones, ifb.p2_tens, ifb.p2_ones};
  pong_match_controller #(.WIN_SCORE(15), .SERVE_TICKS(3), .POINT_TICKS(2)) dut_a (
    .clk(clk), .clr(clr), .m(ifa));
  pong_match_controller #(.WIN_SCORE(3), .SERVE_TICKS(0), .POINT_TICKS(0)) dut_b (
    .clk(clk), .clr(clr), .m(ifb));
  typedef struct {
    int          cyc;
    int          d;
    string       name;
    logic [20:0] exp;
    logic [20:0] mask;
  } item_t;
  item_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [20:0] ALL = 21'h1FFFFF;
  localparam logic [20:0] NO_WIN = 21'h1EFFFF;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    item_t it;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      n_cmp++;
      if ((outv[it.d] & it.mask) !== (it.exp & it.mask)) begin
        n_bad++;
        $display("FAIL %s dut%0d: got %h expected %h (mask %h)", it.name, it.d, outv[it.d], it.exp, it.mask);
      end
    end
  end
  function automatic logic [20:0] ov(bit run, bit br, bit sd, bit go, bit w, int p1, int p2);
    return {run, br, sd, go, w, 4'(p1 / 10), 4'(p1 % 10), 4'(p2 / 10), 4'(p2 % 10)};
  endfunction
  task automatic chk(input int d, input string nm, input logic [20:0] e, input logic [20:0] mk);
    sb.push_back('{cyc, d, nm, e, mk});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_tick(input int d);
    tick[d] = 1'b1;
    step();
    tick[d] = 1'b0;
    step();
  endtask
  task automatic press(input int d);
    start[d] = 1'b0;
    step();
    start[d] = 1'b1;
    step();
  endtask
  task automatic score(input int d, input bit a, input bit b);
    sp1[d] = a;
    sp2[d] = b;
    step();
    sp1[d] = 1'b0;
    sp2[d] = 1'b0;
  endtask
  task automatic finish_a();
    repeat (5) pulse_tick(0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int k = 0; k < 2; k++) begin
      tick[k] = 1'b0;
      start[k] = 1'b0;
      sp1[k] = 1'b0;
      sp2[k] = 1'b0;
    end
    start[0] = 1'b1;
    step();
    chk(0, "reset_1", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    step();
    chk(0, "reset_2", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    clr = 1'b0;
    repeat (3) pulse_tick(0);
    chk(0, "held_no_press", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    press(0);
    chk(0, "serve_entry", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    pulse_tick(0);
    pulse_tick(0);
    chk(0, "serve_after_2", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    tick[0] = 1'b1;
    step();
    tick[0] = 1'b0;
    chk(0, "play_at_3rd", ov(1, 0, 0, 0, 0, 0, 0), ALL);
    for (int i = 1; i <= 12; i++) begin
      score(0, 0, 1);
      chk(0, "p2_point", ov(0, 1, 0, 0, 0, 0, i), ALL);
      finish_a();
      chk(0, "p2_replay", ov(1, 0, 0, 0, 0, 0, i), ALL);
    end
    score(0, 1, 1);
    chk(0, "both_scores", ov(0, 1, 1, 0, 0, 1, 12), ALL);
    finish_a();
    chk(0, "both_replay", ov(1, 0, 1, 0, 0, 1, 12), ALL);
    start[0] = 1'b0;
    step();
    start[0] = 1'b1;
    score(0, 1, 0);
    chk(0, "press_and_score", ov(0, 1, 1, 0, 0, 2, 12), ALL);
    finish_a();
    chk(0, "press_score_replay", ov(1, 0, 1, 0, 0, 2, 12), ALL);
    press(0);
    chk(0, "pause", ov(0, 0, 1, 0, 0, 2, 12), ALL);
    score(0, 1, 0);
    pulse_tick(0);
    chk(0, "pause_score_ignored", ov(0, 0, 1, 0, 0, 2, 12), ALL);
    press(0);
    chk(0, "unpause", ov(1, 0, 1, 0, 0, 2, 12), ALL);
    for (int i = 13; i <= 15; i++) begin
      score(0, 0, 1);
      chk(0, "p2_late_point", ov(0, 1, 0, 0, 0, 2, i), ALL);
      if (i < 15) finish_a();
    end
    pulse_tick(0);
    chk(0, "win_point_hold", ov(0, 1, 0, 0, 0, 2, 15), ALL);
    pulse_tick(0);
    chk(0, "game_over_p2", ov(0, 1, 0, 1, 1, 2, 15), ALL);
    score(0, 1, 0);
    step();
    chk(0, "over_score_ignored", ov(0, 1, 0, 1, 1, 2, 15), ALL);
    press(0);
    chk(0, "over_to_idle", ov(0, 1, 0, 0, 0, 0, 0), NO_WIN);
    press(0);
    repeat (3) pulse_tick(0);
    chk(0, "rematch_play", ov(1, 0, 0, 0, 0, 0, 0), NO_WIN);
    for (int i = 1; i <= 7; i++) begin
      score(0, 1, 0);
      finish_a();
    end
    for (int i = 1; i <= 4; i++) begin
      score(0, 0, 1);
      finish_a();
    end
    chk(0, "score_07_04", ov(1, 0, 0, 0, 0, 7, 4), NO_WIN);
    clr = 1'b1;
    step();
    chk(0, "mid_reset", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    clr = 1'b0;
    step();
    chk(0, "mid_reset_held", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    press(0);
    pulse_tick(0);
    pulse_tick(0);
    chk(0, "restart_serve_2", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    tick[0] = 1'b1;
    step();
    tick[0] = 1'b0;
    chk(0, "restart_play_3rd", ov(1, 0, 0, 0, 0, 0, 0), ALL);
    press(1);
    chk(0 + 1, "b_serve_zero", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    step();
    chk(1, "b_play_1clk", ov(1, 0, 0, 0, 0, 0, 0), ALL);
    for (int i = 1; i <= 3; i++) begin
      score(1, 1, 0);
      chk(1, "b_point", ov(0, 1, 1, 0, 0, i, 0), ALL);
      step();
      if (i < 3) begin
        chk(1, "b_serve", ov(0, 1, 1, 0, 0, i, 0), ALL);
        step();
        chk(1, "b_play", ov(1, 0, 1, 0, 0, i, 0), ALL);
      end
    end
    chk(1, "b_game_over", ov(0, 1, 1, 1, 0, 3, 0), ALL);
    score(1, 0, 1);
    step();
    chk(1, "b_over_p2_ignored", ov(0, 1, 1, 1, 0, 3, 0), ALL);
    press(1);
    chk(1, "b_over_to_idle", ov(0, 1, 0, 0, 0, 0, 0), ALL);
    repeat (3) step();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
